// File: rtl/lsu_pkg.sv
// Shared constants and encodings for the load/store unit.
// Imported by the interface, lane aligner and top.
package lsu_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic req_bad(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == SZ_ILL) ||
           (size == SZ_HALF && off[0]) ||
           (size == SZ_WORD && off != 2'd0);
  endfunction
endpackage

// File: rtl/lsu_if.sv
// Request/response channel between execute stage and LSU.
// master = execute stage, slave = load/store unit.
interface lsu_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size,
    output req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads and
// lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [15:0]       wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] store_o
);
  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsh = {off_i, 3'b000};
  assign hsh = {off_i[1], 4'b0000};
  assign b   = word_i[bsh +: 8];
  assign h   = word_i[hsh +: 16];

  always_comb begin
    load_o  = word_i;
    store_o = word_i;
    unique case (1'b1)
      (size_i == SZ_BYTE): begin
        load_o  = {{24{~uns_i & b[7]}}, b};
        store_o = (word_i & ~(32'h0000_00ff << bsh))
                | ({24'b0, wdata_i[7:0]} << bsh);
      end
      (size_i == SZ_HALF): begin
        load_o  = {{16{~uns_i & h[15]}}, h};
        store_o = (word_i & ~(32'h0000_ffff << hsh))
                | ({16'b0, wdata_i} << hsh);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a
// word-addressed data memory; sub-word stores use RMW.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  lsu_if.slave              bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              rdy_q, rdy_d;
  logic              rv_q, rv_d;
  logic              re_q, re_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwd_q, mwd_d;
  logic [DATA_W-1:0] load_w, store_w;

  lsu_lane_align u_align (
    .word_i  (mem_read_data),
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .wdata_i (wdata_q),
    .load_o  (load_w),
    .store_o (store_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rdy_d   = rdy_q;
    rv_d    = rv_q;
    re_d    = re_q;
    rdata_d = rdata_q;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    unique case (state_q)
      ST_IDLE: if (bus.req_valid) begin
        rdy_d   = 1'b0;
        write_d = bus.req_write;
        uns_d   = bus.req_unsigned;
        size_d  = bus.req_size;
        off_d   = bus.req_addr[1:0];
        wdata_d = bus.req_wdata[15:0];
        err_d   = req_bad(bus.req_size, bus.req_addr[1:0]);
        cnt_d   = 2'd0;
        // Errors pass through WR with no strobe for a 1-cycle reply.
        if (err_d) begin
          state_d = ST_WR;
        end else begin
          maddr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
          if (bus.req_write && bus.req_size == SZ_WORD) begin
            mwr_d   = 1'b1;
            mwd_d   = bus.req_wdata;
            state_d = ST_WR;
          end else begin
            mrd_d   = 1'b1;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == 2'(MEM_RD_LAT)) begin
          mrd_d = 1'b0;
          cnt_d = 2'd0;
          if (write_q) begin
            mwr_d   = 1'b1;
            mwd_d   = store_w;
            state_d = ST_WR;
          end else begin
            rv_d    = 1'b1;
            re_d    = 1'b0;
            rdata_d = load_w;
            state_d = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_WR: begin
        mwr_d   = 1'b0;
        rv_d    = 1'b1;
        re_d    = err_q;
        rdata_d = '0;
        state_d = ST_RESP;
      end
      ST_RESP: if (bus.resp_ready) begin
        rv_d    = 1'b0;
        re_d    = 1'b0;
        rdata_d = '0;
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      off_q   <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b1;
      rv_q    <= 1'b0;
      re_q    <= 1'b0;
      rdata_q <= '0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      rv_q    <= rv_d;
      re_q    <= re_d;
      rdata_q <= rdata_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
    end
  end

  assign bus.req_ready   = rdy_q;
  assign bus.resp_valid  = rv_q;
  assign bus.resp_err    = re_q;
  assign bus.resp_rdata  = rdata_q;
  assign mem_read        = mrd_q;
  assign mem_write       = mwr_q;
  assign mem_address     = maddr_q;
  assign mem_write_data  = mwd_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small
// behavioural word memory honouring MEM_RD_LAT.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int L = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clock = ~clock;

  lsu_if bus ();

  load_store_unit #(.MEM_RD_LAT(L)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  logic [31:0] mem [0:63];
  int rdc = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_both = 0;
  logic [7:0]  wr_a = '0;
  logic [31:0] wr_d = '0;

  always @(posedge clock) begin
    if (mem_write) begin
      mem[mem_address[7:2]] <= mem_write_data;
      n_wr <= n_wr + 1;
      wr_a <= mem_address;
      wr_d <= mem_write_data;
    end
    if (mem_read) n_rd <= n_rd + 1;
    if (mem_read && mem_write) n_both <= n_both + 1;
    rdc <= mem_read ? rdc + 1 : 0;
  end

  assign mem_read_data = (mem_read && rdc >= L) ?
                         mem[mem_address[7:2]] : 32'hDEAD_BEEF;

  int total = 0;
  int bad = 0;

  task automatic send(
    input  logic        w,
    input  logic [1:0]  sz,
    input  logic        u,
    input  logic [7:0]  a,
    input  logic [31:0] wd,
    output int          lat,
    output logic [31:0] rd,
    output logic        e,
    output int          drd,
    output int          dwr
  );
    int r0, w0, k;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clock); k++; end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL send_ready got=%0b want=1", bus.req_ready);
    end
    r0 = n_rd; w0 = n_wr;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clock); @(negedge clock);
    bus.req_valid = 1'b0; bus.req_write = ~w; bus.req_size = 2'd3;
    bus.req_unsigned = ~u; bus.req_addr = 8'hFF;
    bus.req_wdata = 32'hA5A5_5A5A;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin @(negedge clock); lat++; end
    rd = bus.resp_rdata; e = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    bus.resp_ready = 1'b0;
    drd = n_rd - r0; dwr = n_wr - w0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%0b want=1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0b want=0", bus.resp_valid); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err got=%0b want=0", bus.resp_err); end
    total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.resp_rdata); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL rst_mem_read got=%0b want=0", mem_read); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rst_mem_write got=%0b want=0", mem_write); end
    total++; if (mem_address !== 8'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_address); end
    total++; if (mem_write_data !== 32'h0) begin bad++; $display("FAIL rst_mem_wd got=%h want=0", mem_write_data); end
  endtask

  task automatic test_word_store_load();
    int lat, drd, dwr; logic [31:0] rd; logic e;
    send(1'b1, SZ_WORD, 1'b0, 8'h04, 32'h0000_0002, lat, rd, e, drd, dwr);
    total++; if (lat != 1) begin bad++; $display("FAIL ws_lat got=%0d want=1", lat); end
    total++; if (dwr != 1) begin bad++; $display("FAIL ws_nwr got=%0d want=1", dwr); end
    total++; if (drd != 0) begin bad++; $display("FAIL ws_nrd got=%0d want=0", drd); end
    total++; if (wr_a !== 8'h04) begin bad++; $display("FAIL ws_addr got=%h want=04", wr_a); end
    total++; if (wr_d !== 32'h2) begin bad++; $display("FAIL ws_data got=%h want=2", wr_d); end
    total++; if (rd !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL ws_resp got=%h/%0b want=0/0", rd, e); end
    send(1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0, lat, rd, e, drd, dwr);
    total++; if (lat != L + 1) begin bad++; $display("FAIL wl_lat got=%0d want=%0d", lat, L + 1); end
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL wl_rdata got=%h want=2", rd); end
    total++; if (drd != L + 1) begin bad++; $display("FAIL wl_nrd got=%0d want=%0d", drd, L + 1); end
    total++; if (dwr != 0) begin bad++; $display("FAIL wl_nwr got=%0d want=0", dwr); end
  endtask

  task automatic test_load_extend();
    int lat, drd, dwr; logic [31:0] rd; logic e;
    send(1'b1, SZ_WORD, 1'b0, 8'h08, 32'h8070_F005, lat, rd, e, drd, dwr);
    send(1'b0, SZ_BYTE, 1'b0, 8'h0A, 32'h0, lat, rd, e, drd, dwr);
    total++; if (rd !== 32'h0000_0070) begin bad++; $display("FAIL lb_0a got=%h want=00000070", rd); end
    total++; if (lat != L + 1) begin bad++; $display("FAIL lb_lat got=%0d want=%0d", lat, L + 1); end
    send(1'b0, SZ_BYTE, 1'b0, 8'h0B, 32'h0, lat, rd, e, drd, dwr);
    total++; if (rd !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_0b got=%h want=ffffff80", rd); end
    send(1'b0, SZ_BYTE, 1'b1, 8'h0B, 32'h0, lat, rd, e, drd, dwr);
    total++; if (rd !== 32'h0000_0080) begin bad++; $display("FAIL lbu_0b got=%h want=00000080", rd); end
    send(1'b0, SZ_BYTE, 1'b1, 8'h09, 32'h0, lat, rd, e, drd, dwr);
    total++; if (rd !== 32'h0000_00F0) begin bad++; $display("FAIL lbu_09 got=%h want=000000f0", rd); end
    send(1'b0, SZ_HALF, 1'b0, 8'h08, 32'h0, lat, rd, e, drd, dwr);
    total++; if (rd !== 32'hFFFF_F005) begin bad++; $display("FAIL lh_08 got=%h want=fffff005", rd); end
    send(1'b0, SZ_HALF, 1'b1, 8'h0A, 32'h0, lat, rd, e, drd, dwr);
    total++; if (rd !== 32'h0000_8070) begin bad++; $display("FAIL lhu_0a got=%h want=00008070", rd); end
    send(1'b0, SZ_WORD, 1'b0, 8'h08, 32'h0, lat, rd, e, drd, dwr);
    total++; if (rd !== 32'h8070_F005) begin bad++; $display("FAIL lw_08 got=%h want=8070f005", rd); end
  endtask

  task automatic test_subword_store();
    int lat, drd, dwr; logic [31:0] rd; logic e;
    send(1'b1, SZ_WORD, 1'b0, 8'h0C, 32'h1122_3344, lat, rd, e, drd, dwr);
    send(1'b1, SZ_BYTE, 1'b0, 8'h0D, 32'h0000_00AB, lat, rd, e, drd, dwr);
    total++; if (lat != L + 2) begin bad++; $display("FAIL sb_lat got=%0d want=%0d", lat, L + 2); end
    total++; if (drd != L + 1 || dwr != 1) begin bad++; $display("FAIL sb_acc got=rd%0d/wr%0d want=rd%0d/wr1", drd, dwr, L + 1); end
    total++; if (wr_d !== 32'h1122_AB44) begin bad++; $display("FAIL sb_wdata got=%h want=1122ab44", wr_d); end
    total++; if (wr_a !== 8'h0C) begin bad++; $display("FAIL sb_addr got=%h want=0c", wr_a); end
    send(1'b1, SZ_HALF, 1'b0, 8'h0E, 32'hFFFF_BEEF, lat, rd, e, drd, dwr);
    total++; if (wr_d !== 32'hBEEF_AB44) begin bad++; $display("FAIL sh_wdata got=%h want=beefab44", wr_d); end
    send(1'b0, SZ_WORD, 1'b0, 8'h0C, 32'h0, lat, rd, e, drd, dwr);
    total++; if (rd !== 32'hBEEF_AB44) begin bad++; $display("FAIL sw_readback got=%h want=beefab44", rd); end
  endtask

  task automatic test_errors();
    int lat, drd, dwr; logic [31:0] rd; logic e;
    send(1'b0, SZ_HALF, 1'b0, 8'h09, 32'h0, lat, rd, e, drd, dwr);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_lh got=%0b/%h want=1/0", e, rd); end
    total++; if (lat != 1) begin bad++; $display("FAIL err_lat got=%0d want=1", lat); end
    total++; if (drd != 0 || dwr != 0) begin bad++; $display("FAIL err_lh_acc got=%0d/%0d want=0/0", drd, dwr); end
    send(1'b1, SZ_WORD, 1'b0, 8'h1A, 32'hCAFE_F00D, lat, rd, e, drd, dwr);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_sw got=%0b/%h want=1/0", e, rd); end
    total++; if (drd != 0 || dwr != 0) begin bad++; $display("FAIL err_sw_acc got=%0d/%0d want=0/0", drd, dwr); end
    send(1'b0, SZ_ILL, 1'b0, 8'h00, 32'h0, lat, rd, e, drd, dwr);
    total++; if (e !== 1'b1 || drd != 0) begin bad++; $display("FAIL err_ill got=%0b/%0d want=1/0", e, drd); end
    send(1'b0, SZ_HALF, 1'b0, 8'h0A, 32'h0, lat, rd, e, drd, dwr);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL ok_lh_err got=%0b want=0", e); end
  endtask

  task automatic test_stall();
    int k, r0;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = SZ_WORD;
    bus.req_unsigned = 1'b0; bus.req_addr = 8'h04;
    @(posedge clock); @(negedge clock);
    bus.req_addr = 8'h08;
    k = 0;
    while (!bus.resp_valid && k < 20) begin @(negedge clock); k++; end
    r0 = n_rd;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h2) begin bad++; $display("FAIL stall_hold got=%0b/%h want=1/2", bus.resp_valid, bus.resp_rdata); end
      total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%0b want=0", bus.req_ready); end
      @(negedge clock);
    end
    total++; if (n_rd != r0) begin bad++; $display("FAIL stall_acc got=%0d want=0", n_rd - r0); end
    bus.resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    bus.resp_ready = 1'b0;
    total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL stall_retire got=%0b/%0b want=1/0", bus.req_ready, bus.resp_valid); end
    @(posedge clock); @(negedge clock);
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.resp_valid && k < 20) begin @(negedge clock); k++; end
    total++; if (bus.resp_rdata !== 32'h8070_F005) begin bad++; $display("FAIL stall_next got=%h want=8070f005", bus.resp_rdata); end
    bus.resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, drd, dwr, w0; logic [31:0] rd; logic e;
    send(1'b1, SZ_WORD, 1'b0, 8'h20, 32'h5566_7788, lat, rd, e, drd, dwr);
    w0 = n_wr;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SZ_BYTE;
    bus.req_unsigned = 1'b0; bus.req_addr = 8'h21; bus.req_wdata = 32'h11;
    @(posedge clock); @(negedge clock);
    bus.req_valid = 1'b0;
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL rm_in_rd got=%0b want=1", mem_read); end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rm_hs got=%0b/%0b want=1/0", bus.req_ready, bus.resp_valid); end
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rm_strobes got=%0b/%0b want=0/0", mem_read, mem_write); end
    total++; if (mem_address !== 8'h0 || mem_write_data !== 32'h0) begin bad++; $display("FAIL rm_bus got=%h/%h want=0/0", mem_address, mem_write_data); end
    repeat (4) @(negedge clock);
    total++; if (n_wr != w0 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rm_quiet got=%0d/%0b want=0/0", n_wr - w0, bus.resp_valid); end
    send(1'b0, SZ_WORD, 1'b0, 8'h20, 32'h0, lat, rd, e, drd, dwr);
    total++; if (rd !== 32'h5566_7788) begin bad++; $display("FAIL rm_readback got=%h want=55667788", rd); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_word_store_load();
    test_load_extend();
    test_subword_store();
    test_errors();
    test_stall();
    test_reset_mid();
    total++; if (n_both != 0) begin bad++; $display("FAIL rd_wr_overlap got=%0d want=0", n_both); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
